// File: rtl/priority_encoder_rr.sv
// rtl/priority_encoder_rr.sv - registered priority encoder, fixed or round-robin
// The round-robin search descends from ptr with wrap; ptr moves just below each winner.
module priority_encoder_rr #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         rr,
  input  logic [N-1:0] x,
  output logic [W-1:0] y,
  output logic [N-1:0] gnt,
  output logic         z
);

  logic [W-1:0] ptr;
  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] scan;
  logic         rr_hit;
  logic [W-1:0] win;
  logic [W-1:0] ptr_next;
  logic [N-1:0] onehot;

  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) fix_idx = W'(i);
    end
  end

  // Scan index is ptr - i modulo N; adding N on underflow keeps it in 0..N-1
  // for non-power-of-two N as well.
  always_comb begin
    rr_idx = '0;
    rr_hit = 1'b0;
    scan   = '0;
    for (int i = 0; i < N; i++) begin
      scan = ptr - W'(i);
      if (W'(i) > ptr) scan = scan + W'(N);
      if (!rr_hit && x[scan]) begin
        rr_hit = 1'b1;
        rr_idx = scan;
      end
    end
  end

  always_comb begin
    win      = rr ? rr_idx : fix_idx;
    ptr_next = (win == '0) ? W'(N - 1) : win - W'(1);
    onehot   = {{(N-1){1'b0}}, 1'b1} << win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      gnt <= '0;
      z   <= 1'b0;
      ptr <= W'(N - 1);
    end else if (en && (|x)) begin
      y   <= win;
      gnt <= onehot;
      z   <= 1'b1;
      ptr <= ptr_next;
    end else begin
      y   <= '0;
      gnt <= '0;
      z   <= 1'b0;
    end
  end

endmodule

// File: doc/priority_encoder_rr.md
PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning number of request inputs (legal range 2..64).
REQ-002 The block SHALL have derived parameter W, default $clog2(N), meaning encoded output width; W is not overridden by instantiators.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port en  input  1  encoder enable.
REQ-006 The block SHALL have port rr  input  1  mode select: 0 = fixed priority, 1 = round-robin.
REQ-007 The block SHALL have port x  input  N  request vector.
REQ-008 The block SHALL have port y  output  W  registered encoded index of the winning request.
REQ-009 The block SHALL have port gnt  output  N  registered one-hot grant, gnt[y] = 1 when z = 1.
REQ-010 The block SHALL have port z  output  1  registered valid flag, 1 when a request won.

Function
REQ-011 All outputs SHALL be registered: inputs sampled at rising edge k appear on y/gnt/z after edge k, one-cycle latency, no combinational input-to-output path.
REQ-012 With en = 0 at an edge, the block SHALL load y = 0, gnt = 0, z = 0 and leave the round-robin pointer ptr unchanged.
REQ-013 With en = 1 and x = 0 at an edge, the block SHALL load y = 0, gnt = 0, z = 0 and leave ptr unchanged.
REQ-014 With en = 1, rr = 0, x != 0, the winner SHALL be the highest set bit index of x.
REQ-015 With en = 1, rr = 1, x != 0, the search SHALL start at index ptr and descend ptr, ptr-1, ..., 0, N-1, ..., ptr+1 (wrap 0 -> N-1); the first set bit found wins.
REQ-016 On any edge that produces z = 1 (either mode), ptr SHALL load (g == 0) ? N-1 : g-1, where g is the winning index.
REQ-017 ptr SHALL be internal, W bits, always in 0..N-1, including non-power-of-two N.
REQ-018 Toggling rr between edges SHALL NOT reset ptr; the next rr = 1 edge uses the current ptr.
REQ-019 With a single requester held, the block SHALL grant it every cycle in both modes.
REQ-020 With all bits of x set and rr = 1, successive grants SHALL cycle N-1, N-2, ..., 0, N-1, ... with no skip or repeat.
REQ-021 gnt SHALL be exactly one-hot when z = 1 and all-zero when z = 0; y SHALL equal 0 when z = 0.

Reset
REQ-022 rst_n = 0 SHALL immediately, without a clock edge, force y = 0, gnt = 0, z = 0, ptr = N-1.
REQ-023 Reset asserted mid-operation SHALL discard the in-flight grant; the first edge after rst_n rises SHALL behave as after power-up (ptr = N-1).
REQ-024 Deassertion of rst_n SHALL be sampled synchronously to clk by the instantiating logic; the block itself adds no synchroniser.

Verification (N = 4 unless stated)
REQ-025 Reset: drive rst_n = 0 between edges with z = 1 -> y = 0, gnt = 0000, z = 0 before the next edge.
REQ-026 Fixed sweep: en = 1, rr = 0, x = 0..15 one per cycle -> one cycle later y = index of highest set bit, z = (x != 0); e.g. x = 0110 -> y = 2, gnt = 0100, z = 1.
REQ-027 Enable off: en = 0, x = 1111 for 3 cycles -> y = 0, gnt = 0000, z = 0; ptr unchanged (next rr = 1, x = 1111 grant equals the grant expected before the en = 0 gap).
REQ-028 Round-robin rotation: rr = 1, x = 1111 for 6 cycles after reset -> y = 3, 2, 1, 0, 3, 2.
REQ-029 Round-robin sparse/wrap: after grant y = 0 (ptr = 3), x = 0011 -> y = 1; then x = 0101 -> y = 0 (search 0); then x = 1001 -> y = 3 (wrap from 0 to 3).
REQ-030 Non-power-of-two: N = 5, rr = 1, x = 11111 -> y = 4, 3, 2, 1, 0, 4; ptr never takes values 5..7.
